// File: rtl/seq_booth_mul.sv
// Iterative Booth multiplier with start/done handshake; signed or unsigned operands.
// Define BOOTH_RADIX4_EN for radix-4 recoding (2 bits/cycle), otherwise radix-2 (1 bit/cycle).
module seq_booth_mul #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

`ifdef BOOTH_RADIX4_EN
    localparam int N  = WIDTH + 2;
    localparam int AW = N + 1;            // one extra bit of headroom for +/-2M
    localparam int SH = 2;
    localparam int K  = (WIDTH + 2) / 2;
`else
    localparam int N  = WIDTH + 1;
    localparam int AW = N;
    localparam int SH = 1;
    localparam int K  = WIDTH + 1;
`endif
    localparam int CW = $clog2(K + 1);
    localparam int SW = AW + N + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_a;
    logic [AW-1:0]   r_m;
    logic [N-1:0]    r_q;
    logic            r_qm1;
    logic [CW-1:0]   r_cnt;

    logic [AW-1:0]   w_m_ext;
    logic [N-1:0]    w_q_ext;
    logic [AW-1:0]   w_sum;
    logic [SW-1:0]   w_shift;
    logic [AW-1:0]   w_a_next;
    logic [N-1:0]    w_q_next;
    logic            w_qm1_next;
    logic [2*WIDTH-1:0] w_prod;

    // Unsigned operands get zero-extended so the Booth top digit never reads as negative.
    assign w_m_ext = {{(AW-WIDTH){is_signed & multiplicand[WIDTH-1]}}, multiplicand};
    assign w_q_ext = {{(N-WIDTH){is_signed & multiplier[WIDTH-1]}}, multiplier};

    always_comb begin
        // NOTE: w_sum gets a default before the case so no path leaves it unassigned (no latch).
        w_sum = r_a;
`ifdef BOOTH_RADIX4_EN
        case ({r_q[1:0], r_qm1})
            3'b001, 3'b010: w_sum = r_a + r_m;
            3'b011:         w_sum = r_a + (r_m << 1);
            3'b100:         w_sum = r_a - (r_m << 1);
            3'b101, 3'b110: w_sum = r_a - r_m;
            default:        w_sum = r_a;
        endcase
`else
        case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
`endif
    end

    assign w_shift    = $signed({w_sum, r_q, r_qm1}) >>> SH;
    assign w_a_next   = w_shift[SW-1 -: AW];
    assign w_q_next   = w_shift[N:1];
    assign w_qm1_next = w_shift[0];
    assign w_prod     = w_shift[2*WIDTH:1];

    // NOTE: all state is sequential and uses non-blocking assignments only.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_m     <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_cnt   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= '0;
                        r_m     <= w_m_ext;
                        r_q     <= w_q_ext;
                        r_qm1   <= 1'b0;
                        r_cnt   <= CW'(K - 1);
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a   <= w_a_next;
                    r_q   <= w_q_next;
                    r_qm1 <= w_qm1_next;
                    if (r_cnt == '0) begin
                        product <= w_prod;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= '0;
                        r_m     <= w_m_ext;
                        r_q     <= w_q_ext;
                        r_qm1   <= 1'b0;
                        r_cnt   <= CW'(K - 1);
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_booth_mul.sv
// Directed and small random checks of seq_booth_mul at WIDTH=32 (either recoding build).
module tb_seq_booth_mul;

`ifdef BOOTH_RADIX4_EN
    localparam int K = 17;
`else
    localparam int K = 33;
`endif

    logic        clock;
    logic        clear;
    logic        start;
    logic        is_signed;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [63:0] product;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_mis = 0;

    seq_booth_mul #(.WIDTH(32)) dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .is_signed    (is_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a start at a negedge; return at the negedge after the sampling edge, operands scrambled.
    task automatic issue(input logic s, input logic [31:0] m, input logic [31:0] q);
        start        = 1'b1;
        is_signed    = s;
        multiplicand = m;
        multiplier   = q;
        @(negedge clock);
        start        = 1'b0;
        is_signed    = ~s;
        multiplicand = ~m;
        multiplier   = q ^ 32'h5a5a_a5a5;
    endtask

    task automatic wait_done(output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (done !== 1'b1 && n < 200) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clock);
            n++;
        end
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] m, input logic [31:0] q);
        longint sm, sq;
        logic [63:0] um, uq;
        sm = longint'($signed(m));
        sq = longint'($signed(q));
        um = {32'b0, m};
        uq = {32'b0, q};
        return s ? 64'(sm * sq) : (um * uq);
    endfunction

    initial begin
        int n, nb, seen;
        logic [31:0] rm, rq;
        logic rs;

        clear = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        repeat (2) @(negedge clock);
        check("reset_product", product, 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);
        clear = 1'b0;
        @(negedge clock);

        // Signed small with latency and busy length
        issue(1'b1, 32'd7, 32'hFFFF_FFFD);
        wait_done(n, nb);
        check("s7xm3_latency", 64'(n), 64'(K));
        check("s7xm3_busy_cycles", 64'(nb), 64'(K));
        check("s7xm3_product", product, 64'hFFFF_FFFF_FFFF_FFEB);
        check("s7xm3_busy_at_done", 64'(busy), 64'h0);
        @(negedge clock);
        check("done_one_cycle", 64'(done), 64'h0);
        check("idle_busy_low", 64'(busy), 64'h0);

        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n, nb);
        check("umax_product", product, 64'hFFFF_FFFE_0000_0001);
        @(negedge clock);

        issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n, nb);
        check("smax_product", product, 64'h0000_0000_0000_0001);
        @(negedge clock);

        issue(1'b1, 32'h8000_0000, 32'h8000_0000);
        wait_done(n, nb);
        check("smin_sq_product", product, 64'h4000_0000_0000_0000);
        @(negedge clock);

        issue(1'b1, 32'h8000_0000, 32'd1);
        wait_done(n, nb);
        check("smin_x1_product", product, 64'hFFFF_FFFF_8000_0000);
        @(negedge clock);

        // start during RUN is ignored; product holds until completion
        issue(1'b0, 32'd3, 32'd4);
        repeat (3) @(negedge clock);
        start = 1'b1;
        multiplicand = 32'd9;
        multiplier = 32'd9;
        @(negedge clock);
        start = 1'b0;
        check("run_product_stable", product, 64'hFFFF_FFFF_8000_0000);
        check("run_busy", 64'(busy), 64'h1);
        wait_done(n, nb);
        check("ignored_start_latency", 64'(n), 64'(K - 4));
        check("ignored_start_product", product, 64'd12);
        @(negedge clock);

        // Back-to-back: start held into DONE launches the next op with no gap
        issue(1'b0, 32'd11, 32'd13);
        wait_done(n, nb);
        check("b2b_first_product", product, 64'd143);
        start = 1'b1;
        is_signed = 1'b0;
        multiplicand = 32'd5;
        multiplier = 32'd6;
        @(negedge clock);
        start = 1'b0;
        multiplicand = 32'd77;
        check("b2b_busy_no_gap", 64'(busy), 64'h1);
        check("b2b_done_dropped", 64'(done), 64'h0);
        wait_done(n, nb);
        check("b2b_second_latency", 64'(n), 64'(K));
        check("b2b_second_product", product, 64'd30);
        repeat (5) @(negedge clock);
        check("idle_product_hold", product, 64'd30);

        // Clear mid-RUN
        issue(1'b0, 32'd100, 32'd200);
        repeat (5) @(negedge clock);
        clear = 1'b1;
        #1;
        check("clear_busy", 64'(busy), 64'h0);
        check("clear_done", 64'(done), 64'h0);
        check("clear_product", product, 64'h0);
        @(negedge clock);
        clear = 1'b0;
        seen = 0;
        for (int i = 0; i < K + 5; i++) begin
            @(negedge clock);
            if (done === 1'b1) seen++;
        end
        check("clear_no_done", 64'(seen), 64'h0);
        issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n, nb);
        check("after_clear_product", product, 64'd1);
        @(negedge clock);

        // Random operands in both modes against a behavioural 64-bit multiply
        for (int i = 0; i < 200; i++) begin
            rm = $urandom;
            rq = $urandom;
            rs = 1'($urandom_range(0, 1));
            issue(rs, rm, rq);
            wait_done(n, nb);
            check(rs ? "rand_signed" : "rand_unsigned", product, model(rs, rm, rq));
            @(negedge clock);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
